// File: rtl/vecmat_dot_stream.sv
// vecmat_dot_stream: pipelined multi-beat signed dot product with saturated fixed-point result
module vecmat_dot_stream #(
  parameter int LANES = 32,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int GUARD = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LANES*DW-1:0]   s_vector,
  input  logic [LANES*DW-1:0]   s_matrix,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [DW-1:0]         m_data,
  output logic                  m_sat,
  output logic                  m_valid,
  input  logic                  m_ready
);
  localparam int L    = $clog2(LANES);
  localparam int PW   = 2 * DW;
  localparam int TW   = PW + L;
  localparam int ACCW = TW + GUARD;

  logic                   w_en;
  logic [L:0]             r_vld;
  logic [L:0]             r_lst;
  logic signed [TW-1:0]   w_tree;
  logic signed [ACCW-1:0] w_acc_new;
  logic signed [ACCW-1:0] w_shr;
  logic [ACCW-DW:0]       w_top;
  logic                   w_fit;
  logic signed [ACCW-1:0] r_acc;
  logic signed [ACCW-1:0] r_res;
  logic                   r_first;
  logic                   r_res_vld;

  assign w_en    = !(m_valid && !m_ready);
  assign s_ready = w_en;

  // valid and last markers travel with the product and tree stages
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_vld <= '0;
      r_lst <= '0;
    end else if (w_en) begin
      r_vld <= {r_vld[L-1:0], s_valid};
      r_lst <= {r_lst[L-1:0], s_valid & s_last};
    end

  genvar j;
  generate
    for (j = 0; j <= L; j++) begin : lvl
      localparam int W = PW + j;
      localparam int N = LANES >> j;
      logic signed [W-1:0] r_sum [N];
      if (j == 0) begin : g_p
        // full-precision lane products, no rounding
        always_ff @(posedge clk or negedge reset)
          if (!reset) begin
            for (int k = 0; k < N; k++) r_sum[k] <= '0;
          end else if (w_en) begin
            for (int k = 0; k < N; k++)
              r_sum[k] <= PW'($signed(s_vector[k*DW +: DW])) * PW'($signed(s_matrix[k*DW +: DW]));
          end
      end else begin : g_t
        // one adder-tree level, widened by a bit so it cannot overflow
        always_ff @(posedge clk or negedge reset)
          if (!reset) begin
            for (int k = 0; k < N; k++) r_sum[k] <= '0;
          end else if (w_en) begin
            for (int k = 0; k < N; k++)
              r_sum[k] <= {lvl[j-1].r_sum[2*k][W-2], lvl[j-1].r_sum[2*k]} +
                          {lvl[j-1].r_sum[2*k+1][W-2], lvl[j-1].r_sum[2*k+1]};
          end
      end
    end
  endgenerate

  assign w_tree    = lvl[L].r_sum[0];
  assign w_acc_new = (r_first ? '0 : r_acc) + {{GUARD{w_tree[TW-1]}}, w_tree};

  // multi-beat accumulation; a last beat hands the full sum to the output stage
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_acc     <= '0;
      r_res     <= '0;
      r_first   <= 1'b1;
      r_res_vld <= 1'b0;
    end else if (w_en) begin
      r_res_vld <= r_vld[L] & r_lst[L];
      if (r_vld[L]) begin
        if (r_lst[L]) begin
          r_res   <= w_acc_new;
          r_first <= 1'b1;
        end else begin
          r_acc   <= w_acc_new;
          r_first <= 1'b0;
        end
      end
    end

  assign w_shr = r_res >>> FRAC;
  assign w_top = w_shr[ACCW-1:DW-1];
  assign w_fit = (&w_top) | ~(|w_top);

  // floor-scaled, clamped result register; holds while the consumer stalls
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sat   <= 1'b0;
    end else if (w_en) begin
      m_valid <= r_res_vld;
      if (r_res_vld) begin
        m_data <= w_fit ? w_shr[DW-1:0] : {w_shr[ACCW-1], {(DW-1){~w_shr[ACCW-1]}}};
        m_sat  <= !w_fit;
      end
    end
endmodule

// File: doc/vecmat_dot_stream.md
# vecmat_dot_stream

Parametrised, fully pipelined streaming fixed-point dot-product engine for the attention datapath: LANES signed multipliers, a registered adder tree and a wide multi-beat accumulator. A vector of any length is streamed in LANES-element beats, and one saturated DW-bit result is produced per vector. Both sides use valid/ready handshakes. It is the drop-in successor to the fixed 32-lane softmax×V multiply-add pair.

## Interface
Parameters:
- LANES, 32: elements per beat; power of two, ≥2; L = log2(LANES).
- DW, 16: element and result width, signed two's complement.
- FRAC, 8: fractional bits of every element and of the result.
- GUARD, 8: extra accumulator headroom bits; ACCW = 2*DW + L + GUARD.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_vector  in  LANES*DW  vector elements; lane i = bits [i*DW +: DW].
- s_matrix  in  LANES*DW  matrix-column elements, same lane packing.
- s_valid  in  1  input beat valid.
- s_last  in  1  beat is the final beat of the current vector.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- m_data  out  DW  saturated dot product, Q(DW-FRAC).FRAC.
- m_sat  out  1  m_data was clipped.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result when m_valid && m_ready.

## Operation
- Global enable: en = !(m_valid && !m_ready). s_ready = en. When en=0, every pipeline register, including valid/last bits and the accumulator, holds its value.
- Stage P (product): on accept, register LANES full-precision 2*DW-bit signed products a_i*b_i, plus valid and last. No rounding here.
- Stages T1..TL: each adder-tree level is registered. Level j sums pairs at width 2*DW+j with sign extension, so the tree never overflows. Valid/last travel alongside.
- Stage A (accumulate), on a valid beat leaving TL:
  - acc_new = (first ? 0 : acc) + sign-extended tree sum, in ACCW bits.
  - first is set by reset and after every last beat.
  - If last: r = acc_new >>> FRAC, an arithmetic shift that truncates toward −∞.
  - m_data = r clamped to [−2^(DW−1), 2^(DW−1)−1]. m_sat = 1 iff clamped. m_valid is set and first is set.
  - Otherwise: acc = acc_new and first is cleared.
- The accumulator wraps in two's complement only beyond 2^GUARD beats per vector. Longer vectors are a caller error with an undefined result.
- m_valid clears on the edge where m_valid && m_ready, unless a new result lands on the same edge. In that case m_data and m_sat are replaced and m_valid stays 1.
- A stream of single-beat vectors (s_last=1 every beat) produces one result per beat.
- While reset is low: every valid bit = 0, acc = 0, first = 1, m_valid = 0, m_data = 0, m_sat = 0. s_ready = 1 at reset. Partial accumulations in flight are discarded.

## Timing
- Latency: a last beat accepted at edge k gives m_valid = 1 after edge k+L+2. With LANES=32 this is 7 edges.
- Throughput: one beat per cycle when m_ready is held high.
- Backpressure: s_ready falls combinationally in the same cycle that m_valid=1 and m_ready=0. Beats already in the pipeline freeze in place and none are dropped or duplicated. Flow resumes on the cycle after m_ready rises.
- s_last is sampled only when a beat is accepted. s_valid may toggle freely and bubbles are allowed anywhere in a vector.
- m_data and m_sat are stable while m_valid && !m_ready.

## Test plan
- Single beat, DW=16, FRAC=8, LANES=32: all lanes vector=0x0100, matrix=0x0100, s_last=1 → m_data=0x2000, m_sat=0, m_valid 7 edges after acceptance.
- Three beats, all lanes vector=0x0080, matrix=0x0200, last on beat 3, with a 2-cycle bubble after beat 1 → exactly one result, m_data=0x6000, m_sat=0.
- Saturation cases:
  - All lanes 0x7FFF×0x7FFF → m_data=0x7FFF, m_sat=1.
  - All lanes 0x8000×0x7FFF → m_data=0x8000, m_sat=1.
- Truncation, lane 0 only, others zero:
  - 0x0001×0x0080 → m_data=0x0000.
  - 0xFFFF×0x0080 → m_data=0xFFFF (floor of −0.5 LSB).
- Backpressure: back-to-back single-beat vectors with lane-0 vector values 1..20 (scaled), m_ready low for 10 cycles mid-stream → s_ready low while stalled; all 20 results emitted in order with none lost or repeated.
- Reset mid-vector: two non-last beats of all 0x0100, pull reset low for one cycle, then one last beat of all 0x0100 → m_valid=0 and m_data=0 during reset; the single result is 0x2000 with no stale sum.
